custom_axi_scratchpad: RTL

AXI4 slave (responder) scratchpad memory that terminates the CPU-side AXI master port, the opposite end of the core's peripheral-bus master. It serves INCR/FIXED bursts from a LUT-based word array with independent read and write channel FSMs and one outstanding transaction per direction. It sits behind the system crossbar as a small data/scratch region for bring-up and self-tests.

---
 rtl/custom_axi_scratchpad.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/custom_axi_scratchpad.sv
// AXI4 slave scratchpad: LUT-style word array with independent read and write
// burst engines, one outstanding transaction per direction.
module custom_axi_scratchpad #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned LANES      = DATA_WIDTH / 8;
  localparam int unsigned LANE_SHIFT = $clog2(LANES);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_BYTES = ADDR_WIDTH'(LANES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Borrow bit of the widened subtraction flags addresses below BASE_ADDR.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && ((diff[ADDR_WIDTH-1:0] >> LANE_SHIFT) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LANE_SHIFT);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wstate_t               r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen;
  logic [7:0]            r_wcnt;
  logic [1:0]            r_wburst;
  logic                  r_werr;

  rstate_t               r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen;
  logic [7:0]            r_rcnt;
  logic [1:0]            r_rburst;

  logic                  w_wbeat;
  logic                  w_wfinal;
  logic                  w_wok;
  logic [ADDR_WIDTH-1:0] w_waddr_next;
  logic [ADDR_WIDTH-1:0] w_raddr_next;
  logic [ADDR_WIDTH-1:0] w_rfetch_addr;
  logic                  w_rfetch_ok;
  logic [DATA_WIDTH-1:0] w_rfetch_data;
  logic                  w_unused;

  assign w_unused = ^{s_axi_awsize, s_axi_arsize};

  assign w_wbeat      = r_wready && s_axi_wvalid;
  assign w_wfinal     = (r_wcnt == r_wlen);
  assign w_wok        = addr_ok(r_waddr);
  assign w_waddr_next = (r_wburst == BURST_FIXED) ? r_waddr : r_waddr + LANE_BYTES;

  // In R_IDLE the fetch targets araddr so the first beat is ready one cycle after AR.
  assign w_raddr_next  = (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + LANE_BYTES;
  assign w_rfetch_addr = (r_rstate == R_IDLE) ? s_axi_araddr : w_raddr_next;
  assign w_rfetch_ok   = addr_ok(w_rfetch_addr);
  assign w_rfetch_data = w_rfetch_ok ? r_mem[addr_idx(w_rfetch_addr)] : '0;

  always_ff @(posedge clk) begin
    if (w_wbeat && w_wok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (s_axi_wstrb[i]) begin
          r_mem[addr_idx(r_waddr)][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_bid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wburst  <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready && s_axi_awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= s_axi_awid;
            r_waddr   <= s_axi_awaddr;
            r_wlen    <= s_axi_awlen;
            r_wburst  <= s_axi_awburst;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= w_waddr_next;
            // Beat count alone ends the burst; wlast only feeds the response.
            if (w_wfinal) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || !w_wok || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt <= r_wcnt + 8'd1;
              r_werr <= r_werr || !w_wok || s_axi_wlast;
            end
          end
        end
        W_RESP: begin
          if (r_bvalid && s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= '0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rburst  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready && s_axi_arvalid) begin
            r_arready <= 1'b0;
            r_rid     <= s_axi_arid;
            r_raddr   <= s_axi_araddr;
            r_rlen    <= s_axi_arlen;
            r_rburst  <= s_axi_arburst;
            r_rcnt    <= '0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rfetch_data;
            r_rresp   <= w_rfetch_ok ? RESP_OKAY : RESP_SLVERR;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_rvalid && s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_raddr_next;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= w_rfetch_data;
              r_rresp <= w_rfetch_ok ? RESP_OKAY : RESP_SLVERR;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;

endmodule
